freq_meter: RTL and testbench

- Measures the frequency of a slow, asynchronous square wave such as a divided clock or an external tick, in the clk domain.
- Counts clk cycles between successive rising edges of sig_in to give period.
- Computes freq = floor(BASE_SPEED / period) with a sequential restoring divider.
- Results feed status displays and self-check logic, closing the loop on clock generation.

---
 rtl/freq_meter.sv | 197 +++++++++++++++++++
 tb/tb_freq_meter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: period and frequency meter for a slow asynchronous input.
// Define FREQ_METER_DUTY_EN to add the high_time (high-phase) output.
module freq_meter #(
   parameter  int BASE_SPEED = 50000000,
   parameter  int MAX_PERIOD = 50000000,
   localparam int CW = $clog2(MAX_PERIOD) + 1,
   localparam int QW = $clog2(BASE_SPEED) + 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          sig_in,
   output logic [CW-1:0] period,
   output logic [QW-1:0] freq,
   output logic          valid,
   output logic          timeout,
   output logic          overrun
`ifdef FREQ_METER_DUTY_EN
   ,
   output logic [CW-1:0] high_time
`endif
);

   localparam int IW = $clog2(QW) + 1;

   typedef enum logic {WAIT_FIRST, COUNT} state_t;

   state_t          r_state;
   state_t          w_state_nx;
   logic            r_s1, r_s2, r_s3;
   logic            w_edge;
   logic [CW-1:0]   r_cnt;
   logic [CW-1:0]   w_cnt_nx;
   logic            w_accept;
   logic            w_drop;
   logic            w_tmo;

   logic            r_busy;
   logic [IW-1:0]   r_iter;
   logic [CW-1:0]   r_dsr;
   logic [CW:0]     r_rem;
   logic [QW-1:0]   r_quo;
   logic [QW-1:0]   r_dvd;
   logic [CW:0]     w_shift;
   logic            w_ge;
   logic [CW:0]     w_rem_nx;
   logic [QW-1:0]   w_quo_nx;
   logic            w_last;

   logic [CW-1:0]   r_period;
   logic [QW-1:0]   r_freq;
   logic            r_valid;
   logic            r_timeout;
   logic            r_overrun;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= sig_in;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_edge = r_s2 & ~r_s3;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= WAIT_FIRST;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // An edge always wins over the timeout in the same cycle
   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_accept   = 1'b0;
      w_drop     = 1'b0;
      w_tmo      = 1'b0;
      unique case (r_state)
         WAIT_FIRST: begin
            w_cnt_nx = '0;
            if (w_edge) begin
               w_cnt_nx   = CW'(1);
               w_state_nx = COUNT;
            end
         end
         COUNT: begin
            if (w_edge) begin
               w_cnt_nx = CW'(1);
               if (r_busy) w_drop = 1'b1;
               else        w_accept = 1'b1;
            end else if (r_cnt == CW'(MAX_PERIOD)) begin
               w_tmo      = 1'b1;
               w_cnt_nx   = '0;
               w_state_nx = WAIT_FIRST;
            end else begin
               w_cnt_nx = r_cnt + CW'(1);
            end
         end
         default: begin
            w_state_nx = WAIT_FIRST;
            w_cnt_nx   = '0;
         end
      endcase
   end

   assign w_shift  = {r_rem[CW-1:0], r_dvd[QW-1]};
   assign w_ge     = (w_shift >= {1'b0, r_dsr});
   assign w_rem_nx = w_ge ? (w_shift - {1'b0, r_dsr}) : w_shift;
   assign w_quo_nx = {r_quo[QW-2:0], w_ge};
   assign w_last   = r_busy && (r_iter == IW'(QW - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_iter <= '0;
         r_dsr  <= '0;
         r_rem  <= '0;
         r_quo  <= '0;
         r_dvd  <= '0;
      end else if (w_accept) begin
         r_busy <= 1'b1;
         r_iter <= '0;
         r_dsr  <= r_cnt;
         r_rem  <= '0;
         r_quo  <= '0;
         r_dvd  <= QW'(BASE_SPEED);
      end else if (r_busy) begin
         r_rem  <= w_rem_nx;
         r_quo  <= w_quo_nx;
         r_dvd  <= {r_dvd[QW-2:0], 1'b0};
         r_iter <= r_iter + IW'(1);
         if (w_last) r_busy <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_period  <= '0;
         r_freq    <= '0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (w_last) begin
            r_period  <= r_dsr;
            r_freq    <= w_quo_nx;
            r_valid   <= 1'b1;
            r_timeout <= 1'b0;
         end else if (w_tmo) begin
            r_period  <= '0;
            r_freq    <= '0;
            r_timeout <= 1'b1;
         end
         if (w_drop) r_overrun <= 1'b1;
      end
   end

   assign period  = r_period;
   assign freq    = r_freq;
   assign valid   = r_valid;
   assign timeout = r_timeout;
   assign overrun = r_overrun;

`ifdef FREQ_METER_DUTY_EN
   logic [CW-1:0] r_hcnt;
   logic [CW-1:0] r_hsh;
   logic [CW-1:0] r_high;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_hcnt <= '0;
         r_hsh  <= '0;
         r_high <= '0;
      end else begin
         if (w_edge)
            r_hcnt <= CW'(1);
         else if (r_s2 && (r_hcnt != CW'(MAX_PERIOD)))
            r_hcnt <= r_hcnt + CW'(1);
         if (w_accept) r_hsh <= r_hcnt;
         if (w_last)     r_high <= r_hsh;
         else if (w_tmo) r_high <= '0;
      end
   end

   assign high_time = r_high;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: randomized and directed checks of freq_meter against
// an edge-timeline reference model (BASE_SPEED=MAX_PERIOD=1000).
module tb_freq_meter;

   localparam int BASE = 1000;
   localparam int MAXP = 1000;
   localparam int CW   = $clog2(MAXP) + 1;
   localparam int QW   = $clog2(BASE) + 1;

   typedef struct {
      int c;
      int p;
      int f;
      int h;
   } ev_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          sig_in;
   logic [CW-1:0] period;
   logic [QW-1:0] freq;
   logic          valid;
   logic          timeout;
   logic          overrun;
   int            hv;
`ifdef FREQ_METER_DUTY_EN
   logic [CW-1:0] high_time;
   assign hv = int'(high_time);
`else
   assign hv = 0;
`endif

   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   ovr_cyc  = -1;
   ev_t  obs_q[$];
   ev_t  exp_q[$];
   int   rise_q[$];
   int   hi_q[$];

   freq_meter #(.BASE_SPEED(BASE), .MAX_PERIOD(MAXP)) dut (
      .clk     (clk),
      .reset   (reset),
      .sig_in  (sig_in),
      .period  (period),
      .freq    (freq),
      .valid   (valid),
      .timeout (timeout),
      .overrun (overrun)
`ifdef FREQ_METER_DUTY_EN
      ,
      .high_time (high_time)
`endif
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset && valid)
         obs_q.push_back('{cyc, int'(period), int'(freq), hv});
      if (!reset && overrun && ovr_cyc < 0)
         ovr_cyc = cyc;
   end

   task automatic apply_reset();
      sig_in = 1'b0;
      reset  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset   = 1'b0;
      ovr_cyc = -1;
      obs_q.delete();
      rise_q.delete();
      hi_q.delete();
   endtask

   task automatic pulse(input int h, input int l);
      @(posedge clk);
      #1;
      sig_in = 1'b1;
      rise_q.push_back(cyc);
      hi_q.push_back(h);
      repeat (h) @(posedge clk);
      #1;
      sig_in = 1'b0;
      repeat (l - 1) @(posedge clk);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Edge timeline model: detect = rise+2, results at detect+QW+1
   task automatic build_model(output bit ovr);
      bit started;
      int last;
      int lasth;
      int free_at;
      started = 0;
      last    = 0;
      lasth   = 0;
      free_at = 0;
      ovr     = 0;
      exp_q.delete();
      foreach (rise_q[i]) begin
         int d;
         d = rise_q[i] + 2;
         if (started && d > last + MAXP) started = 0;
         if (!started) begin
            started = 1;
         end else if (d < free_at) begin
            ovr = 1;
         end else begin
            exp_q.push_back('{d + QW + 1, d - last, BASE / (d - last), lasth});
            free_at = d + QW + 1;
         end
         last  = d;
         lasth = hi_q[i];
      end
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      sig_in = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (period !== '0 || freq !== '0) begin
         failures++;
         $display("FAIL reset_pf got %0d/%0d want 0/0", period, freq);
      end
      checks++;
      if (valid !== 1'b0 || timeout !== 1'b0 || overrun !== 1'b0) begin
         failures++;
         $display("FAIL reset_flags got %b%b%b want 000", valid, timeout, overrun);
      end
      checks++;
      if (hv !== 0) begin
         failures++;
         $display("FAIL reset_high got %0d want 0", hv);
      end
   endtask

   task automatic test_waveform(input string nm, input int hl, input int hh,
                                input int ll, input int lh, input int n);
      bit eovr;
      apply_reset();
      for (int i = 0; i < n; i++) begin
         int h;
         int l;
         h = $urandom_range(hh, hl);
         l = $urandom_range(lh, ll);
         pulse(h, l);
      end
      idle(QW + 6);
      build_model(eovr);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL %s_count got %0d want %0d", nm, obs_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (obs_q[i].c != exp_q[i].c || obs_q[i].p != exp_q[i].p ||
                obs_q[i].f != exp_q[i].f) begin
               failures++;
               $display("FAIL %s_ev%0d got c%0d p%0d f%0d want c%0d p%0d f%0d",
                        nm, i, obs_q[i].c, obs_q[i].p, obs_q[i].f,
                        exp_q[i].c, exp_q[i].p, exp_q[i].f);
            end
`ifdef FREQ_METER_DUTY_EN
            checks++;
            if (obs_q[i].h != exp_q[i].h) begin
               failures++;
               $display("FAIL %s_hi%0d got %0d want %0d", nm, i, obs_q[i].h, exp_q[i].h);
            end
`endif
         end
      end
      checks++;
      if (overrun !== eovr) begin
         failures++;
         $display("FAIL %s_overrun got %b want %b", nm, overrun, eovr);
      end
   endtask

   task automatic test_fast3();
      int t0;
      apply_reset();
      t0 = cyc;
      repeat (8) pulse(2, 1);
      idle(QW + 6);
      checks++;
      if (ovr_cyc < 0 || ovr_cyc - t0 > 15) begin
         failures++;
         $display("FAIL fast3_overrun got cycle %0d want <= %0d", ovr_cyc - t0, 15);
      end
      checks++;
      if (obs_q.size() == 0) begin
         failures++;
         $display("FAIL fast3_result got 0 results want >0");
      end else if (obs_q[0].p != 3 || obs_q[0].f != 333) begin
         failures++;
         $display("FAIL fast3_result got p%0d f%0d want p3 f333", obs_q[0].p, obs_q[0].f);
      end
   endtask

   task automatic test_timeout();
      int dl;
      apply_reset();
      pulse(5, 5);
      pulse(5, 5);
      dl = rise_q[1] + 2;
      while (cyc < dl + MAXP) @(negedge clk);
      checks++;
      if (timeout !== 1'b0 || period !== CW'(10)) begin
         failures++;
         $display("FAIL tmo_before got t%b p%0d want t0 p10", timeout, period);
      end
      @(negedge clk);
      checks++;
      if (timeout !== 1'b1 || period !== '0 || freq !== '0) begin
         failures++;
         $display("FAIL tmo_set got t%b p%0d f%0d want t1 p0 f0", timeout, period, freq);
      end
      checks++;
      if (obs_q.size() != 1) begin
         failures++;
         $display("FAIL tmo_valids got %0d want 1", obs_q.size());
      end
      obs_q.delete();
      repeat (3) pulse(10, 10);
      idle(QW + 6);
      checks++;
      if (obs_q.size() == 0 || obs_q[0].p != 20 || obs_q[0].f != 50) begin
         failures++;
         $display("FAIL tmo_resume got n%0d want p20 f50", obs_q.size());
      end
      checks++;
      if (timeout !== 1'b0) begin
         failures++;
         $display("FAIL tmo_clear got %b want 0", timeout);
      end
   endtask

   task automatic test_reset_mid();
      apply_reset();
      pulse(4, 4);
      pulse(4, 4);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      idle(QW + 4);
      checks++;
      if (obs_q.size() != 0) begin
         failures++;
         $display("FAIL rmid_valid got %0d want 0", obs_q.size());
      end
      checks++;
      if (period !== '0 || freq !== '0 || timeout !== 1'b0 ||
          overrun !== 1'b0 || hv !== 0) begin
         failures++;
         $display("FAIL rmid_outs got p%0d f%0d t%b o%b h%0d want all 0",
                  period, freq, timeout, overrun, hv);
      end
      repeat (3) pulse(4, 4);
      idle(QW + 6);
      checks++;
      if (obs_q.size() == 0 || obs_q[0].p != 8 || obs_q[0].f != 125) begin
         failures++;
         $display("FAIL rmid_next got n%0d want p8 f125", obs_q.size());
      end
   endtask

`ifdef FREQ_METER_DUTY_EN
   task automatic test_duty();
      apply_reset();
      repeat (3) pulse(3, 7);
      idle(QW + 6);
      checks++;
      if (obs_q.size() == 0 || obs_q[0].h != 3 || obs_q[0].p != 10) begin
         failures++;
         $display("FAIL duty got n%0d want h3 p10", obs_q.size());
      end
   endtask
`endif

   initial begin
      reset  = 1'b1;
      sig_in = 1'b0;
      test_reset();
      test_waveform("sq10", 5, 5, 5, 5, 6);
      test_fast3();
      test_timeout();
      test_reset_mid();
      for (int r = 0; r < 4; r++)
         test_waveform("rand", 1, 6, 1, 25, 12);
`ifdef FREQ_METER_DUTY_EN
      test_duty();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
